spi_command_decoder: RTL

SPI_COMMAND_DECODER -- requirements
Module: spi_command_decoder

---
 rtl/spi_command_decoder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/spi_command_decoder.sv
// SPI mode-0 command receiver: synchronizes SCLK/CS/MOSI, collects a fixed-length frame and
// decodes note-on / note-off commands. Define SPI_CHECKSUM_EN for an 8-byte frame with XOR checksum.
module spi_command_decoder (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_sclk,
    input  logic        i_cs_n,
    input  logic        i_mosi,
    output logic        o_SPI_flag_dds,
    output logic        o_SPI_flag_adsr,
    output logic        o_SPI_note_status,
    output logic [7:0]  o_SPI_voice_index,
    output logic [7:0]  o_SPI_velocity,
    output logic [31:0] o_SPI_tuning_code,
    output logic        o_frame_error
);

`ifdef SPI_CHECKSUM_EN
    localparam int unsigned FRAME_BYTES = 8;
`else
    localparam int unsigned FRAME_BYTES = 7;
`endif
    localparam int unsigned FRAME_BITS   = FRAME_BYTES * 8;
    localparam int unsigned PAYLOAD_BITS = 56;
    localparam int unsigned CNT_W        = 7;
    localparam logic [7:0]  CMD_NOTE_ON  = 8'h90;
    localparam logic [7:0]  CMD_NOTE_OFF = 8'h80;

    typedef enum logic [1:0] {IDLE, SHIFT, DECODE, WAIT_CS} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [1:0]              sclk_ff;
    logic [1:0]              cs_ff;
    logic [1:0]              mosi_ff;
    logic                    sclk_prev;
    logic                    cs_prev;
    logic [1:0]              sync_fill;
    logic [CNT_W-1:0]        bit_cnt;
    logic [FRAME_BITS-1:0]   shift_reg;
    logic [PAYLOAD_BITS-1:0] payload;
    logic                    sync_ready_c;
    logic                    sclk_rise_c;
    logic                    cs_fall_c;
    logic                    cs_high_c;
    logic                    last_bit_c;
    logic                    csum_ok_c;
    logic                    load_on_c;
    logic                    load_off_c;
    logic                    frame_err_c;

    // Edges are only trusted once both sync and history stages hold real input samples,
    // so a CS already low when reset releases is not mistaken for a new frame start.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sclk_ff   <= 2'b00;
            cs_ff     <= 2'b11;
            mosi_ff   <= 2'b00;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
            sync_fill <= 2'd0;
        end else begin
            sclk_ff   <= {sclk_ff[0], i_sclk};
            cs_ff     <= {cs_ff[0], i_cs_n};
            mosi_ff   <= {mosi_ff[0], i_mosi};
            sclk_prev <= sclk_ff[1];
            cs_prev   <= cs_ff[1];
            sync_fill <= sync_ready_c ? sync_fill : sync_fill + 2'd1;
        end
    end

    assign sync_ready_c = (sync_fill == 2'd3);
    assign sclk_rise_c  = sync_ready_c & sclk_ff[1] & ~sclk_prev;
    assign cs_fall_c    = sync_ready_c & cs_prev & ~cs_ff[1];
    assign cs_high_c    = cs_ff[1];
    assign last_bit_c   = (bit_cnt == CNT_W'(FRAME_BITS - 1));
    assign payload      = shift_reg[FRAME_BITS-1 -: PAYLOAD_BITS];

`ifdef SPI_CHECKSUM_EN
    assign csum_ok_c = (payload[55:48] ^ payload[47:40] ^ payload[39:32] ^ payload[31:24] ^
                        payload[23:16] ^ payload[15:8] ^ payload[7:0]) == shift_reg[7:0];
`else
    assign csum_ok_c = 1'b1;
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic; CS release during SHIFT abandons a partial frame
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cs_fall_c) state_nxt = SHIFT;
            SHIFT: begin
                if (cs_high_c)                     state_nxt = IDLE;
                else if (sclk_rise_c && last_bit_c) state_nxt = DECODE;
            end
            DECODE:  state_nxt = WAIT_CS;
            WAIT_CS: if (cs_high_c) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Decode strobes, valid only in the single DECODE cycle
    always_comb begin
        load_on_c   = 1'b0;
        load_off_c  = 1'b0;
        frame_err_c = 1'b0;
        if (state == DECODE) begin
            if (!csum_ok_c)                         frame_err_c = 1'b1;
            else if (payload[55:48] == CMD_NOTE_ON)  load_on_c   = 1'b1;
            else if (payload[55:48] == CMD_NOTE_OFF) load_off_c  = 1'b1;
            else                                     frame_err_c = 1'b1;
        end
    end

    // Bit counter and MSB-first shift register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (state == IDLE && cs_fall_c) begin
            bit_cnt   <= '0;
        end else if (state == SHIFT && sclk_rise_c && !cs_high_c) begin
            shift_reg <= {shift_reg[FRAME_BITS-2:0], mosi_ff[1]};
            bit_cnt   <= bit_cnt + CNT_W'(1);
        end
    end

    // Registered outputs; flags are single-cycle because DECODE lasts one cycle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_SPI_flag_dds    <= 1'b0;
            o_SPI_flag_adsr   <= 1'b0;
            o_frame_error     <= 1'b0;
            o_SPI_note_status <= 1'b0;
            o_SPI_voice_index <= '0;
            o_SPI_velocity    <= '0;
            o_SPI_tuning_code <= '0;
        end else begin
            o_SPI_flag_dds  <= load_on_c;
            o_SPI_flag_adsr <= load_on_c | load_off_c;
            o_frame_error   <= frame_err_c;
            if (load_on_c) begin
                o_SPI_note_status <= 1'b1;
                o_SPI_voice_index <= payload[47:40];
                o_SPI_velocity    <= payload[39:32];
                o_SPI_tuning_code <= payload[31:0];
            end else if (load_off_c) begin
                o_SPI_note_status <= 1'b0;
                o_SPI_voice_index <= payload[47:40];
            end
        end
    end

endmodule
